// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants for the sprite unit and its OAM DMA writer.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    GET,
    PUT
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam int unsigned OAM_SIZE     = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA writer: a $4014 write stalls the CPU, copies one 256-byte page from the CPU bus
// and streams it into primary OAM starting at the PPU's OAMADDR.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = ppu_pkg::DMA_REG_ADDR,
  parameter int unsigned XFER_LEN     = ppu_pkg::OAM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        reg_we,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_data,
  input  logic [7:0]  oam_addr_base,
  input  logic [7:0]  dma_data_in,
  output logic        cpu_stall,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_dma,
  output logic        busy,
  output logic        done
);
  import ppu_pkg::*;

  // The index counter is always 8 bits wide; the length only sets the terminal count.
  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  base_q, base_d;
  logic        parity_q, parity_d;
  logic        cpu_stall_q, cpu_stall_d;
  logic        dma_rd_q, dma_rd_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_data_q, oam_data_d;
  logic        oam_dma_q, oam_dma_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trigger;

  assign trigger = reg_we && (reg_addr == DMA_REG_ADDR);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    page_d      = page_q;
    base_d      = base_q;
    parity_d    = parity_q;
    cpu_stall_d = cpu_stall_q;
    dma_rd_d    = dma_rd_q;
    dma_addr_d  = dma_addr_q;
    oam_addr_d  = oam_addr_q;
    oam_data_d  = oam_data_q;
    busy_d      = busy_q;
    // Write strobe and completion pulse drop on the very next clk, even with cpu_ce low.
    oam_dma_d   = 1'b0;
    done_d      = 1'b0;

    if (cpu_ce) begin
      parity_d = ~parity_q;
      unique case (state_q)
        IDLE: begin
          if (trigger) begin
            page_d      = reg_data;
            base_d      = oam_addr_base;
            idx_d       = 8'd0;
            cpu_stall_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = HALT;
          end
        end
        HALT: begin
          // An odd cycle here needs one more dummy cycle to line reads up on even cycles.
          if (parity_q) begin
            state_d = ALIGN;
          end else begin
            state_d    = GET;
            dma_rd_d   = 1'b1;
            dma_addr_d = {page_q, idx_q};
          end
        end
        ALIGN: begin
          state_d    = GET;
          dma_rd_d   = 1'b1;
          dma_addr_d = {page_q, idx_q};
        end
        GET: begin
          state_d  = PUT;
          dma_rd_d = 1'b0;
        end
        PUT: begin
          oam_data_d = dma_data_in;
          oam_addr_d = base_q + idx_q;
          oam_dma_d  = 1'b1;
          if (idx_q == LastIdx) begin
            state_d     = IDLE;
            cpu_stall_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_q + 8'd1;
            state_d    = GET;
            dma_rd_d   = 1'b1;
            dma_addr_d = {page_q, idx_q + 8'd1};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 8'd0;
      page_q      <= 8'd0;
      base_q      <= 8'd0;
      parity_q    <= 1'b0;
      cpu_stall_q <= 1'b0;
      dma_rd_q    <= 1'b0;
      dma_addr_q  <= 16'd0;
      oam_addr_q  <= 8'd0;
      oam_data_q  <= 8'd0;
      oam_dma_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      base_q      <= base_d;
      parity_q    <= parity_d;
      cpu_stall_q <= cpu_stall_d;
      dma_rd_q    <= dma_rd_d;
      dma_addr_q  <= dma_addr_d;
      oam_addr_q  <= oam_addr_d;
      oam_data_q  <= oam_data_d;
      oam_dma_q   <= oam_dma_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cpu_stall = cpu_stall_q;
  assign dma_rd    = dma_rd_q;
  assign dma_addr  = dma_addr_q;
  assign oam_addr  = oam_addr_q;
  assign oam_data  = oam_data_q;
  assign oam_dma   = oam_dma_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus pushes expected OAM writes, a monitor pops them.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_ce = 1'b0;
  logic        reg_we = 1'b0;
  logic [15:0] reg_addr = 16'h2000;
  logic [7:0]  reg_data = 8'h00;
  logic [7:0]  oam_addr_base = 8'h00;
  logic [7:0]  dma_data_in;
  logic        cpu_stall, dma_rd, oam_dma, busy, done;
  logic [15:0] dma_addr;
  logic [7:0]  oam_addr, oam_data;

  oam_dma_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_ce        (cpu_ce),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_data      (reg_data),
    .oam_addr_base (oam_addr_base),
    .dma_data_in   (dma_data_in),
    .cpu_stall     (cpu_stall),
    .dma_rd        (dma_rd),
    .dma_addr      (dma_addr),
    .oam_addr      (oam_addr),
    .oam_data      (oam_data),
    .oam_dma       (oam_dma),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Bus memory model: byte at address A is A[7:0] ^ 5A.
  assign dma_data_in = dma_addr[7:0] ^ 8'h5A;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_page = 8'h00;
  int          trig_tag = 0;

  // Monitor-owned observations.
  int          ce_count = 0;
  int          wr_total = 0;
  int          done_total = 0;
  int          stall_total = 0;
  int          seen_tag = 0;
  int          first_rd_ce = 0;
  logic [15:0] first_rd_addr = 16'h0;

  // Driver-owned state.
  int ce_div = 1;
  int div_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) ce_count <= 0;
    else if (cpu_ce) ce_count <= ce_count + 1;
  end

  logic        prev_valid = 1'b0;
  logic        prev_ce = 1'b0;
  logic        prev_dma = 1'b0;
  logic        prev_done = 1'b0;
  logic [41:0] prev_snap = '0;
  logic [41:0] snap;
  logic [15:0] e;

  always @(negedge clk) begin
    snap = {cpu_stall, busy, dma_rd, dma_addr, oam_addr, oam_data};
    if (reset) begin
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (oam_dma) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL oam_wr_unexpected: got addr %0h data %0h, expected no write",
                   oam_addr, oam_data);
        end else begin
          e = exp_q.pop_front();
          chk("oam_wr", {16'h0, oam_addr, oam_data}, {16'h0, e});
        end
        chk("oam_dma_width", prev_dma, 0);
        wr_total++;
      end
      if (done) begin
        done_total++;
        chk("done_width", prev_done, 0);
      end
      if (dma_rd) begin
        chk("dma_page", dma_addr[15:8], exp_page);
        if (seen_tag != trig_tag) begin
          seen_tag      = trig_tag;
          first_rd_ce   = ce_count;
          first_rd_addr = dma_addr;
        end
      end
      if (cpu_ce && cpu_stall) stall_total++;
      // A clk edge without cpu_ce must leave every registered output unchanged.
      if (prev_valid && !prev_ce) begin
        chk("freeze", snap, prev_snap);
        chk("strobe_clear", {oam_dma, done}, 0);
      end
      prev_valid = 1'b1;
    end
    prev_ce   = cpu_ce;
    prev_dma  = oam_dma;
    prev_done = done;
    prev_snap = snap;
  end

  task automatic step();
    @(posedge clk);
    #1;
    reg_we   = 1'b0;
    reg_addr = 16'h2000;
    div_cnt  = div_cnt + 1;
    if (div_cnt >= ce_div) div_cnt = 0;
    cpu_ce = (div_cnt == 0);
  endtask

  // mode: 0 = plain transfer, 1 = second $4014 write at idx 10, 2 = reset at idx 100 in PUT.
  task automatic run_xfer(input logic [7:0] page, input logic [7:0] base, input bit halt_odd,
                          input int div, input int mode);
    int t0, stall0, done0, wr0, k;
    bit finished, injected;
    ce_div   = div;
    finished = 0;
    injected = 0;
    // Trigger edge parity must be the opposite of the wanted HALT-edge parity.
    for (k = 0; k < 20; k++) begin
      step();
      if (cpu_ce && (ce_count[0] != halt_odd)) break;
    end
    exp_page = page;
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(base + 8'(i)), 8'(i) ^ 8'h5A});
    t0       = ce_count;
    stall0   = stall_total;
    done0    = done_total;
    wr0      = wr_total;
    trig_tag = trig_tag + 1;
    reg_we        = 1'b1;
    reg_addr      = 16'h4014;
    reg_data      = page;
    oam_addr_base = base;
    for (k = 0; k < 4000; k++) begin
      step();
      if (mode == 1 && !injected && cpu_ce && (wr_total - wr0) == 10) begin
        reg_we   = 1'b1;
        reg_addr = 16'h4014;
        reg_data = 8'h07;
        injected = 1;
      end
      if (mode == 2 && (wr_total - wr0) == 100 && busy && !dma_rd) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oam_dma", oam_dma, 0);
        chk("rst_dma_rd", dma_rd, 0);
        finished = 1;
        break;
      end
      if (done_total != done0) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      compared++;
      mismatched++;
      $display("FAIL xfer_timeout: got no completion after %0d clks, expected completion", k);
    end else if (mode != 2) begin
      chk("stall_len", stall_total - stall0, halt_odd ? 514 : 513);
      chk("first_rd_lat", first_rd_ce - t0, halt_odd ? 3 : 2);
      chk("first_rd_addr", first_rd_addr, {page, 8'h00});
      chk("wr_count", wr_total - wr0, 256);
      chk("sb_left", exp_q.size(), 0);
      for (int j = 0; j < 8 * div; j++) step();
      chk("busy_after", {busy, cpu_stall}, 0);
      chk("done_count", done_total - done0, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    chk("reset_ctl", {cpu_stall, dma_rd, oam_dma, busy, done}, 0);
    chk("reset_dma_addr", dma_addr, 0);
    chk("reset_oam", {oam_addr, oam_data}, 0);
    reset = 1'b0;
    step();

    run_xfer(8'h02, 8'h00, 1'b0, 1, 0);  // even HALT
    run_xfer(8'h02, 8'h00, 1'b1, 1, 0);  // odd HALT, goes through ALIGN
    run_xfer(8'h03, 8'hFC, 1'b0, 1, 0);  // OAM address wrap
    run_xfer(8'h02, 8'h00, 1'b0, 3, 0);  // cpu_ce every third clk
    run_xfer(8'h02, 8'h00, 1'b0, 1, 1);  // ignored second trigger
    run_xfer(8'h02, 8'h00, 1'b0, 1, 2);  // reset mid-transfer
    run_xfer(8'h05, 8'h10, 1'b1, 1, 0);  // full transfer after the reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
